// File: rtl/cfg_bank_ctrl.sv
// Config-channel decoder: register bank plus NMEM memory ports, with read bursts and error replies.
// Define CFG_SHADOW_EN to double-buffer regs 1..NREG-1 (shadow copied to active on tick).
module cfg_bank_ctrl #(
    parameter int CDW  = 21,
    parameter int CAW  = 15,
    parameter int ATW  = 3,
    parameter int NREG = 16,
    parameter int RAW  = 4,
    parameter int NMEM = 4,
    parameter int MAW  = 12,
    parameter int BLW  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_req_valid,
    output logic                 cfg_req_ready,
    input  logic                 cfg_req_wr,
    input  logic [CAW-1:0]       cfg_req_addr,
    input  logic [CDW-1:0]       cfg_req_wdata,
    input  logic [BLW-1:0]       cfg_req_blen,
    output logic                 cfg_rsp_valid,
    output logic [CDW-1:0]       cfg_rsp_data,
    output logic                 cfg_rsp_err,
    output logic [NMEM-1:0]      mem_we,
    output logic [NMEM-1:0]      mem_re,
    output logic [MAW-1:0]       mem_addr,
    output logic [CDW-1:0]       mem_wdata,
    input  logic [NMEM*CDW-1:0]  mem_rdata,
    output logic [NREG*CDW-1:0]  reg_flat,
    input  logic                 clear_done,
    input  logic                 tick
);

    // Error reply: as many whole 3'b111 groups as fit, upper leftover bits zero.
    function automatic logic [CDW-1:0] errPattern();
        logic [CDW-1:0] p;
        p = '0;
        for (int i = 0; i < CDW; i++) begin
            if (i < 3 * (CDW / 3)) p[i] = 1'b1;
        end
        return p;
    endfunction

    localparam logic [CDW-1:0] ERR_PAT   = errPattern();
    localparam int             CLEAR_BIT = 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t             r_state;
    logic               r_ready;
    logic [ATW-1:0]     r_region;
    logic [MAW-1:0]     r_beatAddr;
    logic [BLW-1:0]     r_beatsLeft;
    logic               r_rspValid;
    logic               r_rspErr;
    logic               r_rspFromMem;
    logic [ATW-1:0]     r_rspPort;
    logic [CDW-1:0]     r_rspData;
    logic [CDW-1:0]     r_active [NREG];
`ifdef CFG_SHADOW_EN
    logic [CDW-1:0]     r_shadow [NREG];
`endif

    logic               w_accept;
    logic               w_issue;
    logic               w_isWr;
    logic [ATW-1:0]     w_region;
    logic [MAW-1:0]     w_addr;
    logic [RAW-1:0]     w_regIdx;
    logic               w_isRegRgn;
    logic               w_isMemRgn;
    logic               w_regOk;
    logic               w_err;
    logic [ATW-1:0]     w_port;
    logic               w_regWr;
    logic [CDW-1:0]     w_regRdata;
    logic [CDW-1:0]     w_rspData;
    logic               w_unused;

    assign w_unused      = ^{cfg_req_addr, tick};
    assign cfg_req_ready = r_ready;
    assign w_accept      = cfg_req_valid && r_ready;

    // The beat in flight comes from the request port in IDLE and from the burst counters in BURST.
    always_comb begin
        w_issue  = 1'b0;
        w_isWr   = 1'b0;
        w_region = r_region;
        w_addr   = r_beatAddr;
        if (r_state == IDLE) begin
            w_issue  = w_accept;
            w_isWr   = cfg_req_wr;
            w_region = cfg_req_addr[CAW-1 -: ATW];
            w_addr   = cfg_req_addr[MAW-1:0];
        end else begin
            w_issue = 1'b1;
        end
        if (rst) w_issue = 1'b0;
    end

    assign w_regIdx   = w_addr[RAW-1:0];
    assign w_isRegRgn = (w_region == '0);
    assign w_isMemRgn = (w_region != '0) && (32'(w_region) <= NMEM);
    assign w_regOk    = (32'(w_regIdx) < NREG);
    assign w_err      = !(w_isMemRgn || (w_isRegRgn && w_regOk));
    assign w_port     = w_region - 1'b1;
    assign w_regWr    = w_issue && w_isWr && w_isRegRgn && w_regOk;

    assign mem_addr  = w_addr;
    assign mem_wdata = cfg_req_wdata;

    always_comb begin
        mem_we = '0;
        mem_re = '0;
        for (int p = 0; p < NMEM; p++) begin
            if (w_issue && w_isMemRgn && (32'(w_port) == p)) begin
                if (w_isWr) mem_we[p] = 1'b1;
                else        mem_re[p] = 1'b1;
            end
        end
    end

    // Register reads see the shadow copy when double-buffering, except the status register.
    always_comb begin
        w_regRdata = '0;
        for (int k = 0; k < NREG; k++) begin
            if (w_regOk && (32'(w_regIdx) == k)) begin
`ifdef CFG_SHADOW_EN
                if (k == 0) w_regRdata = r_active[0];
                else        w_regRdata = r_shadow[k];
`else
                w_regRdata = r_active[k];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_region     <= '0;
            r_beatAddr   <= '0;
            r_beatsLeft  <= '0;
            r_rspValid   <= 1'b0;
            r_rspErr     <= 1'b0;
            r_rspFromMem <= 1'b0;
            r_rspPort    <= '0;
            r_rspData    <= '0;
        end else begin
            r_rspValid   <= w_issue && !w_isWr;
            r_rspErr     <= w_issue && !w_isWr && w_err;
            r_rspFromMem <= w_isMemRgn;
            r_rspPort    <= w_port;
            r_rspData    <= w_err ? ERR_PAT : w_regRdata;
            case (r_state)
                IDLE: begin
                    if (w_accept && !cfg_req_wr && (cfg_req_blen != '0)) begin
                        r_state     <= BURST;
                        r_ready     <= 1'b0;
                        r_region    <= w_region;
                        r_beatAddr  <= w_addr + 1'b1;
                        r_beatsLeft <= cfg_req_blen;
                    end
                end
                BURST: begin
                    r_beatAddr  <= r_beatAddr + 1'b1;
                    r_beatsLeft <= r_beatsLeft - 1'b1;
                    if (r_beatsLeft == 1) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Memory read data arrives one cycle after mem_re, aligned with the registered beat info.
    always_comb begin
        w_rspData = '0;
        if (r_rspValid) begin
            w_rspData = r_rspData;
            if (r_rspFromMem) begin
                for (int p = 0; p < NMEM; p++) begin
                    if (32'(r_rspPort) == p) w_rspData = mem_rdata[p*CDW +: CDW];
                end
            end
        end
    end

    assign cfg_rsp_valid = r_rspValid;
    assign cfg_rsp_err   = r_rspErr;
    assign cfg_rsp_data  = w_rspData;

    // The status write is placed after the clear_done clear so a same-cycle write wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                r_active[k] <= '0;
`ifdef CFG_SHADOW_EN
                r_shadow[k] <= '0;
`endif
            end
        end else begin
            if (clear_done) r_active[0][CLEAR_BIT] <= 1'b0;
`ifdef CFG_SHADOW_EN
            if (tick) begin
                for (int k = 1; k < NREG; k++) r_active[k] <= r_shadow[k];
            end
`endif
            for (int k = 0; k < NREG; k++) begin
                if (w_regWr && (32'(w_regIdx) == k)) begin
`ifdef CFG_SHADOW_EN
                    if (k == 0) r_active[0] <= cfg_req_wdata;
                    else        r_shadow[k] <= cfg_req_wdata;
`else
                    r_active[k] <= cfg_req_wdata;
`endif
                end
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : gRegFlat
        assign reg_flat[g*CDW +: CDW] = r_active[g];
    end

endmodule

// File: tb/tb_cfg_bank_ctrl.sv
// Scoreboard bench for cfg_bank_ctrl (NREG=12 so out-of-range register indices can be hit).
// Works with or without CFG_SHADOW_EN defined.
module tb_cfg_bank_ctrl;

    localparam int CDW  = 21;
    localparam int CAW  = 15;
    localparam int NREG = 12;
    localparam int NMEM = 4;
    localparam int MAW  = 12;
    localparam int BLW  = 8;
    localparam logic [CDW-1:0] ERR_PAT = 21'h1FFFFF;

    typedef struct {
        logic [CDW-1:0] data;
        logic           err;
        int             cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_req_valid;
    logic                cfg_req_ready;
    logic                cfg_req_wr;
    logic [CAW-1:0]      cfg_req_addr;
    logic [CDW-1:0]      cfg_req_wdata;
    logic [BLW-1:0]      cfg_req_blen;
    logic                cfg_rsp_valid;
    logic [CDW-1:0]      cfg_rsp_data;
    logic                cfg_rsp_err;
    logic [NMEM-1:0]     mem_we;
    logic [NMEM-1:0]     mem_re;
    logic [MAW-1:0]      mem_addr;
    logic [CDW-1:0]      mem_wdata;
    logic [NMEM*CDW-1:0] mem_rdata = '0;
    logic [NREG*CDW-1:0] reg_flat;
    logic                clear_done;
    logic                tick;

    int   checkCount = 0;
    int   errCount   = 0;
    int   cyc        = 0;
    exp_t expQ[$];
    logic [CDW-1:0] regModel [NREG];

    cfg_bank_ctrl #(.NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .cfg_req_valid(cfg_req_valid), .cfg_req_ready(cfg_req_ready),
        .cfg_req_wr(cfg_req_wr), .cfg_req_addr(cfg_req_addr),
        .cfg_req_wdata(cfg_req_wdata), .cfg_req_blen(cfg_req_blen),
        .cfg_rsp_valid(cfg_rsp_valid), .cfg_rsp_data(cfg_rsp_data), .cfg_rsp_err(cfg_rsp_err),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .reg_flat(reg_flat),
        .clear_done(clear_done), .tick(tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [CDW-1:0] memFn(input int p, input logic [MAW-1:0] a);
        return 21'((p + 1) * 32'h01357) ^ {9'h0, a};
    endfunction

    // Synchronous-read memories: data for the sampled address one cycle after mem_re.
    always @(posedge clk) begin
        for (int p = 0; p < NMEM; p++) begin
            if (mem_re[p]) mem_rdata[p*CDW +: CDW] <= memFn(p, mem_addr);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [CDW-1:0] regAct(input int k);
        return reg_flat[k*CDW +: CDW];
    endfunction

    function automatic void expectBeat(input logic [2:0] rgn, input logic [MAW-1:0] off,
                                       output logic [CDW-1:0] d, output logic e);
        d = '0;
        e = 1'b0;
        if (rgn == 3'd0) begin
            if (int'(off[3:0]) < NREG) d = regModel[off[3:0]];
            else begin e = 1'b1; d = ERR_PAT; end
        end else if (rgn <= 3'd4) begin
            d = memFn(int'(rgn) - 1, off);
        end else begin
            e = 1'b1;
            d = ERR_PAT;
        end
    endfunction

    task automatic pushRead(input logic [CAW-1:0] addr, input int beats);
        exp_t           e;
        logic [CDW-1:0] d;
        logic           er;
        for (int i = 0; i < beats; i++) begin
            expectBeat(addr[14:12], addr[11:0] + 12'(i), d, er);
            e.data = d;
            e.err  = er;
            e.cyc  = cyc + 1 + i;
            expQ.push_back(e);
        end
    endtask

    // Response monitor: each response must match the front entry and arrive in its expected cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (cfg_rsp_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("rspUnexpected", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("rspData", cfg_rsp_data, e.data);
                checkOutput("rspErr", cfg_rsp_err, e.err);
                checkOutput("rspCycle", cyc, e.cyc);
            end
        end else if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            e = expQ.pop_front();
            checkOutput("rspMissing", 0, 1);
        end
    end

    // Called at a falling edge; drives one request for one cycle and checks beat-0 memory strobes.
    task automatic applyStimulus(input logic wr, input logic [CAW-1:0] addr,
                                 input logic [CDW-1:0] wdata, input logic [BLW-1:0] blen);
        logic [2:0]      rgn;
        logic [NMEM-1:0] expMask;
        rgn     = addr[14:12];
        expMask = (rgn >= 3'd1 && rgn <= 3'd4) ? 4'(1 << (rgn - 3'd1)) : 4'b0;
        cfg_req_valid = 1'b1;
        cfg_req_wr    = wr;
        cfg_req_addr  = addr;
        cfg_req_wdata = wdata;
        cfg_req_blen  = blen;
        #1;
        checkOutput("acceptReady", cfg_req_ready, 1);
        if (wr) begin
            checkOutput("memWe", mem_we, expMask);
            checkOutput("memReOnWrite", mem_re, 0);
            if (expMask != 0) begin
                checkOutput("memWrAddr", mem_addr, addr[11:0]);
                checkOutput("memWdata", mem_wdata, wdata);
            end
            if (rgn == 3'd0 && int'(addr[3:0]) < NREG) regModel[addr[3:0]] = wdata;
        end else begin
            checkOutput("memRe", mem_re, expMask);
            if (expMask != 0) checkOutput("memRdAddr", mem_addr, addr[11:0]);
            pushRead(addr, int'(blen) + 1);
        end
        @(negedge clk);
        cfg_req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (cfg_req_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) checkOutput("readyTimeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("queueDrained", expQ.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        cfg_req_valid = 1'b0;
        cfg_req_wr = 1'b0;
        cfg_req_addr = '0;
        cfg_req_wdata = '0;
        cfg_req_blen = '0;
        clear_done = 1'b0;
        tick = 1'b0;
        for (int k = 0; k < NREG; k++) regModel[k] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("resetReady", cfg_req_ready, 1);
        checkOutput("resetRspValid", cfg_rsp_valid, 0);
        checkOutput("resetRspData", cfg_rsp_data, 0);
        checkOutput("resetRspErr", cfg_rsp_err, 0);
        checkOutput("resetMemWe", mem_we, 0);
        checkOutput("resetMemRe", mem_re, 0);
        checkOutput("resetRegFlat", reg_flat == '0, 1);
        @(negedge clk);

        // Register write and readback.
        applyStimulus(1'b1, 15'h0001, 21'h00ABC, 8'd0);
        #1;
`ifdef CFG_SHADOW_EN
        checkOutput("reg1BeforeTick", regAct(1), 21'h0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        #1;
`endif
        checkOutput("reg1Active", regAct(1), 21'h00ABC);
        checkOutput("readyHeld", cfg_req_ready, 1);
        @(negedge clk);
        applyStimulus(1'b0, 15'h0001, '0, 8'd0);
        drain();

        // Memory read burst with address wrap, then a back-to-back request in the overlap cycle.
        cfg_req_valid = 1'b1;
        cfg_req_wr    = 1'b0;
        cfg_req_addr  = {3'd3, 12'hFFE};
        cfg_req_blen  = 8'd3;
        #1;
        checkOutput("burstAccept", cfg_req_ready, 1);
        checkOutput("burstRe0", mem_re, 4'b0100);
        checkOutput("burstAddr0", mem_addr, 12'hFFE);
        pushRead({3'd3, 12'hFFE}, 4);
        @(negedge clk);
        cfg_req_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            checkOutput("burstRe", mem_re, 4'b0100);
            checkOutput("burstAddr", mem_addr, 12'(12'hFFE + i));
            checkOutput("burstReadyLow", cfg_req_ready, 0);
            @(negedge clk);
        end
        #1;
        checkOutput("burstDoneReady", cfg_req_ready, 1);
        checkOutput("burstDoneRe", mem_re, 0);
        applyStimulus(1'b0, {3'd1, 12'h123}, '0, 8'd1);
        waitIdle();
        drain();

        // Status register: clear_done clears bit1 unless a status write lands in the same cycle.
        applyStimulus(1'b1, 15'h0000, 21'h3, 8'd0);
        #1;
        checkOutput("statusWrite", regAct(0), 21'h3);
        clear_done = 1'b1;
        @(negedge clk);
        clear_done = 1'b0;
        #1;
        checkOutput("clearDone", regAct(0), 21'h1);
        regModel[0] = 21'h1;
        @(negedge clk);
        clear_done = 1'b1;
        applyStimulus(1'b1, 15'h0000, 21'h2, 8'd0);
        clear_done = 1'b0;
        #1;
        checkOutput("clearWriteWins", regAct(0), 21'h2);
        clear_done = 1'b1;
        @(negedge clk);
        clear_done = 1'b0;
        regModel[0] = 21'h0;
        applyStimulus(1'b0, 15'h0000, '0, 8'd0);
        drain();

        // Error decoding on reads and dropped writes.
        applyStimulus(1'b0, {3'd7, 12'h005}, '0, 8'd0);
        applyStimulus(1'b0, 15'h000F, '0, 8'd0);
        applyStimulus(1'b0, 15'h000A, '0, 8'd3);
        waitIdle();
        applyStimulus(1'b0, 15'h000E, '0, 8'd2);
        waitIdle();
        drain();
        applyStimulus(1'b1, {3'd7, 12'h010}, 21'h12345, 8'd0);
        applyStimulus(1'b1, {3'd5, 12'h010}, 21'h12345, 8'd0);
        applyStimulus(1'b1, {3'd4, 12'h3A5}, 21'h0F0F0, 8'd0);
        applyStimulus(1'b1, 15'h000D, 21'h77777, 8'd0);
        #1;
        checkOutput("reg1Untouched", regAct(1), 21'h00ABC);

        // Write alongside tick.
        @(negedge clk);
        tick = 1'b1;
        applyStimulus(1'b1, 15'h0003, 21'h5, 8'd0);
        tick = 1'b0;
        #1;
`ifdef CFG_SHADOW_EN
        checkOutput("tickOldShadow", regAct(3), 21'h0);
`else
        checkOutput("tickIgnoredWrite", regAct(3), 21'h5);
`endif
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        #1;
        checkOutput("tickNext", regAct(3), 21'h5);
        checkOutput("tickReg1", regAct(1), 21'h00ABC);
        @(negedge clk);

        // Reset during the second beat of a six-beat burst.
        cfg_req_valid = 1'b1;
        cfg_req_wr    = 1'b0;
        cfg_req_addr  = {3'd1, 12'h010};
        cfg_req_blen  = 8'd5;
        #1;
        checkOutput("abortAccept", cfg_req_ready, 1);
        pushRead({3'd1, 12'h010}, 1);
        @(negedge clk);
        cfg_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("memReInReset", mem_re, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abortRspValid", cfg_rsp_valid, 0);
        checkOutput("abortReady", cfg_req_ready, 1);
        checkOutput("abortRegsZero", reg_flat == '0, 1);
        repeat (8) @(negedge clk);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
